jtframe_rom_arb: RTL and testbench

Parametrised SDRAM read arbiter sitting between the game core's ROM fetchers and the single-port `sdram_req`/`sdram_ack`/`data_read`/`data_rdy` controller interface of the board layer. It is the multi-channel successor to the single-requester SDRAM path. It serves `CHANNELS` independent requesters, each with a one-word address/data cache, so repeated reads of the same word never touch SDRAM. It halts new traffic and invalidates all caches while a ROM download is active.

---
 rtl/jtframe_rom_arb_pkg.sv | 17 +
 rtl/jtframe_rom_arb_pick.sv | 45 ++++
 rtl/jtframe_rom_arb.sv | 165 ++++++++++++++++
 tb/tb_jtframe_rom_arb.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtframe_rom_arb_pkg.sv
// rtl/jtframe_rom_arb_pkg.sv - shared types and helpers for the multi-channel SDRAM ROM arbiter
package jtframe_rom_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE     = 2'd0,
        ARB_WAIT_ACK = 2'd1,
        ARB_WAIT_RDY = 2'd2
    } arb_state_t;

    localparam int MAX_CHANNELS = 8;

    // Width of a channel index; a single channel still needs one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/jtframe_rom_arb_pick.sv
// rtl/jtframe_rom_arb_pick.sv - combinational winner selection (JTFRAME_ROM_ARB_FIXPRIO_EN selects fixed priority)
import jtframe_rom_arb_pkg::*;

module jtframe_rom_arb_pick #(
    parameter int CHANNELS = 4,
    parameter int IW       = 2
) (
    input  logic [CHANNELS-1:0] miss,
    input  logic [IW-1:0]       ptr,
    output logic [IW-1:0]       winner,
    output logic                any
);

`ifdef JTFRAME_ROM_ARB_FIXPRIO_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr;

    // Lowest-index missing channel wins; scan downwards so the last hit is the lowest index.
    always_comb begin
        winner = '0;
        any    = 1'b0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            if (miss[k]) begin
                winner = IW'(k);
                any    = 1'b1;
            end
        end
    end
`else
    // Round-robin: first missing channel at or after ptr; scan offsets downwards so the smallest offset wins.
    always_comb begin
        winner = '0;
        any    = 1'b0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            int idx;
            idx = (int'(ptr) + k) % CHANNELS;
            if (miss[idx]) begin
                winner = IW'(idx);
                any    = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/jtframe_rom_arb.sv
// rtl/jtframe_rom_arb.sv - multi-channel SDRAM read arbiter with per-channel one-word cache (option: JTFRAME_ROM_ARB_FIXPRIO_EN)
import jtframe_rom_arb_pkg::*;

module jtframe_rom_arb #(
    parameter int CHANNELS = 4,
    parameter int AW       = 22,
    parameter int DW       = 32
) (
    input  logic                   clk_rom,
    input  logic                   rst,
    input  logic                   downloading,
    input  logic [CHANNELS-1:0]    ch_req,
    input  logic [CHANNELS*AW-1:0] ch_addr,
    output logic [CHANNELS-1:0]    ch_ok,
    output logic [CHANNELS*DW-1:0] ch_data,
    output logic                   sdram_req,
    output logic [AW-1:0]          sdram_addr,
    input  logic                   sdram_ack,
    input  logic [DW-1:0]          data_read,
    input  logic                   data_rdy
);

    localparam int IW = idx_width(CHANNELS);

    arb_state_t state, state_nxt;

    logic [CHANNELS-1:0] cvalid;
    logic [AW-1:0]       caddr  [CHANNELS];
    logic [DW-1:0]       cdata  [CHANNELS];
    logic [AW-1:0]       addr_a [CHANNELS];

    logic [CHANNELS-1:0] hit;
    logic [CHANNELS-1:0] miss;
    logic [IW-1:0]       winner_q;
    logic [IW-1:0]       pick_win;
    logic                pick_any;
    logic [IW-1:0]       ptr;
    logic                grant;
    logic                complete;
    logic                dl_seen;

    // Unpack channel addresses, evaluate hits/misses and expose cached words.
    always_comb begin
        hit     = '0;
        miss    = '0;
        ch_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            addr_a[i]            = ch_addr[i*AW +: AW];
            hit[i]               = ch_req[i] && cvalid[i] && (addr_a[i] == caddr[i]);
            miss[i]              = ch_req[i] && !hit[i];
            ch_data[i*DW +: DW]  = cdata[i];
        end
    end

    assign ch_ok = hit;

    jtframe_rom_arb_pick #(
        .CHANNELS (CHANNELS),
        .IW       (IW)
    ) u_pick (
        .miss   (miss),
        .ptr    (ptr),
        .winner (pick_win),
        .any    (pick_any)
    );

`ifdef JTFRAME_ROM_ARB_FIXPRIO_EN
    assign ptr = '0;
`else
    // Round-robin pointer moves just past each winner.
    always_ff @(posedge clk_rom) begin
        if (rst) begin
            ptr <= '0;
        end else if (grant) begin
            ptr <= (pick_win == IW'(CHANNELS - 1)) ? '0 : pick_win + 1'b1;
        end
    end
`endif

    // FSM state register.
    always_ff @(posedge clk_rom) begin
        if (rst) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; grant and complete are single-cycle strobes for the datapath.
    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        complete  = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (pick_any && !downloading) begin
                    grant     = 1'b1;
                    state_nxt = ARB_WAIT_ACK;
                end
            end
            ARB_WAIT_ACK: begin
                if (sdram_ack) begin
                    if (data_rdy) begin
                        complete  = 1'b1;
                        state_nxt = ARB_IDLE;
                    end else begin
                        state_nxt = ARB_WAIT_RDY;
                    end
                end
            end
            ARB_WAIT_RDY: begin
                if (data_rdy) begin
                    complete  = 1'b1;
                    state_nxt = ARB_IDLE;
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    // SDRAM request/address registers and latched winner.
    always_ff @(posedge clk_rom) begin
        if (rst) begin
            sdram_req  <= 1'b0;
            sdram_addr <= '0;
            winner_q   <= '0;
        end else if (grant) begin
            sdram_req  <= 1'b1;
            sdram_addr <= addr_a[pick_win];
            winner_q   <= pick_win;
        end else if (state == ARB_WAIT_ACK && sdram_ack) begin
            sdram_req  <= 1'b0;
        end
    end

    // Remember a download seen during a transaction so its data is never cached.
    always_ff @(posedge clk_rom) begin
        if (rst || grant) begin
            dl_seen <= 1'b0;
        end else if (downloading && state != ARB_IDLE) begin
            dl_seen <= 1'b1;
        end
    end

    // Cache update on completion; a download wipes every entry each cycle.
    always_ff @(posedge clk_rom) begin
        if (rst) begin
            cvalid <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                caddr[i] <= '0;
                cdata[i] <= '0;
            end
        end else begin
            if (complete && !downloading && !dl_seen) begin
                cvalid[winner_q] <= 1'b1;
                caddr[winner_q]  <= sdram_addr;
                cdata[winner_q]  <= data_read;
            end
            if (downloading) begin
                cvalid <= '0;
            end
        end
    end

endmodule

// File: tb/tb_jtframe_rom_arb.sv
// tb/tb_jtframe_rom_arb.sv - scoreboard bench for jtframe_rom_arb
module tb_jtframe_rom_arb;

    localparam int CH = 4;
    localparam int AW = 22;
    localparam int DW = 32;

    logic              clk_rom = 1'b0;
    logic              rst;
    logic              downloading;
    logic [CH-1:0]     ch_req;
    logic [CH*AW-1:0]  ch_addr;
    logic [CH-1:0]     ch_ok;
    logic [CH*DW-1:0]  ch_data;
    logic              sdram_req;
    logic [AW-1:0]     sdram_addr;
    logic              sdram_ack;
    logic [DW-1:0]     data_read;
    logic              data_rdy;

    int checks = 0;
    int errors = 0;
    int req_count = 0;
    logic req_prev = 1'b0;
    logic [AW-1:0] exp_q[$];
    logic [AW-1:0] exp_addr;

    jtframe_rom_arb #(.CHANNELS(CH), .AW(AW), .DW(DW)) dut (
        .clk_rom     (clk_rom),
        .rst         (rst),
        .downloading (downloading),
        .ch_req      (ch_req),
        .ch_addr     (ch_addr),
        .ch_ok       (ch_ok),
        .ch_data     (ch_data),
        .sdram_req   (sdram_req),
        .sdram_addr  (sdram_addr),
        .sdram_ack   (sdram_ack),
        .data_read   (data_read),
        .data_rdy    (data_rdy)
    );

    always #5 clk_rom = ~clk_rom;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: every new SDRAM request is matched against the expected address queue.
    always @(negedge clk_rom) begin
        if (sdram_req === 1'b1 && !req_prev) begin
            req_count++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_req: got request at %h, expected none", sdram_addr);
            end else begin
                exp_addr = exp_q.pop_front();
                if (sdram_addr !== exp_addr) begin
                    errors++;
                    $display("FAIL req_addr: got %h, expected %h", sdram_addr, exp_addr);
                end
            end
        end
        req_prev = (sdram_req === 1'b1);
    end

    task automatic set_addr(input int ch, input logic [AW-1:0] a);
        ch_addr[ch*AW +: AW] = a;
    endtask

    function automatic logic [DW-1:0] data_of(input int ch);
        return ch_data[ch*DW +: DW];
    endfunction

    task automatic wait_req();
        int n = 0;
        while (sdram_req !== 1'b1 && n < 40) begin
            @(negedge clk_rom);
            n++;
        end
        chk("req_seen", sdram_req, 1);
    endtask

    task automatic do_ack(input int dly);
        repeat (dly) @(negedge clk_rom);
        chk("req_held", sdram_req, 1);
        sdram_ack = 1'b1;
        @(negedge clk_rom);
        sdram_ack = 1'b0;
        chk("req_drop", sdram_req, 0);
    endtask

    task automatic do_rdy(input int dly, input logic [DW-1:0] d);
        repeat (dly - 1) @(negedge clk_rom);
        data_rdy  = 1'b1;
        data_read = d;
        @(negedge clk_rom);
        data_rdy  = 1'b0;
        data_read = '0;
    endtask

    task automatic serve(input int ack_dly, input int rdy_dly, input logic [DW-1:0] d);
        wait_req();
        do_ack(ack_dly);
        do_rdy(rdy_dly, d);
    endtask

    initial begin
        int cnt;
        rst = 1'b1; downloading = 1'b0; ch_req = '0; ch_addr = '0;
        sdram_ack = 1'b0; data_read = '0; data_rdy = 1'b0;
        repeat (3) @(negedge clk_rom);
        chk("rst_ok", ch_ok, 0);
        chk("rst_data", {63'd0, |ch_data}, 0);
        chk("rst_req", sdram_req, 0);
        chk("rst_addr", sdram_addr, 0);
        rst = 1'b0;

        // Single miss, then a repeat hit with no SDRAM traffic.
        exp_q.push_back(22'h00100);
        set_addr(0, 22'h00100);
        ch_req = 4'b0001;
        wait_req();
        do_ack(2);
        repeat (2) @(negedge clk_rom);
        data_rdy = 1'b1; data_read = 32'hDEADBEEF;
        #1 chk("t1_ok_before", ch_ok[0], 0);
        @(negedge clk_rom);
        data_rdy = 1'b0; data_read = '0;
        chk("t1_ok_after", ch_ok[0], 1);
        chk("t1_data", data_of(0), 32'hDEADBEEF);
        cnt = req_count;
        repeat (6) @(negedge clk_rom);
        chk("t1_no_new_req", req_count, cnt);
        chk("t1_ok_hold", ch_ok[0], 1);

        // Round-robin from pointer 0 with all channels missing.
        rst = 1'b1; ch_req = '0;
        repeat (2) @(negedge clk_rom);
        rst = 1'b0;
        for (int i = 0; i < CH; i++) begin
            set_addr(i, 22'h01000 + 22'(i * 'h100));
            exp_q.push_back(22'h01000 + 22'(i * 'h100));
        end
        ch_req = 4'b1111;
        for (int i = 0; i < CH; i++) serve(1, 2, 32'hA000_0000 + 32'(i));
        chk("rr_all_ok", ch_ok, 4'hF);
        chk("rr_data2", data_of(2), 32'hA000_0002);
        set_addr(1, 22'h01104);
        set_addr(3, 22'h01304);
        exp_q.push_back(22'h01104);
        exp_q.push_back(22'h01304);
        #1 chk("rr_ok_partial", ch_ok, 4'b0101);
        serve(1, 2, 32'hB1);
        serve(1, 2, 32'hB3);
        chk("rr_ok_again", ch_ok, 4'hF);
        chk("rr_data3", data_of(3), 32'hB3);

`ifdef JTFRAME_ROM_ARB_FIXPRIO_EN
        // Fixed priority: ch2 starves while ch1 keeps missing.
        ch_req = 4'b0110;
        set_addr(1, 22'h07000);
        set_addr(2, 22'h07800);
        for (int n = 0; n < 3; n++) begin
            exp_q.push_back(22'h07000 + 22'(n * 'h10));
            serve(1, 2, 32'hC0 + 32'(n));
            chk("fp_ch2_starved", ch_ok[2], 0);
            if (n < 2) set_addr(1, 22'h07010 + 22'(n * 'h10));
        end
        exp_q.push_back(22'h07800);
        ch_req = 4'b0100;
        serve(1, 2, 32'hC8);
        chk("fp_ch2_ok", ch_ok[2], 1);
`endif

        // Address change while in flight.
        ch_req = 4'b0100;
        set_addr(2, 22'h02000);
        exp_q.push_back(22'h02000);
        wait_req();
        set_addr(2, 22'h02004);
        do_ack(1);
        do_rdy(2, 32'h2222_0000);
        chk("ac_ok_low", ch_ok[2], 0);
        set_addr(2, 22'h02000);
        #1 chk("ac_cached_old", ch_ok[2], 1);
        chk("ac_data_old", data_of(2), 32'h2222_0000);
        @(negedge clk_rom);
        exp_q.push_back(22'h02004);
        set_addr(2, 22'h02004);
        serve(1, 2, 32'h2222_4444);
        chk("ac_ok_new", ch_ok[2], 1);
        chk("ac_data_new", data_of(2), 32'h2222_4444);

        // Download during a ch1 transaction.
        ch_req = 4'b0011;
        set_addr(1, 22'h03000);
        exp_q.push_back(22'h03000);
        #1 chk("dl_ch0_hit", ch_ok[0], 1);
        wait_req();
        do_ack(1);
        downloading = 1'b1;
        @(negedge clk_rom);
        chk("dl_ok_cleared", ch_ok, 0);
        do_rdy(2, 32'h3333_3333);
        chk("dl_ch1_discard", ch_ok[1], 0);
        for (int n = 0; n < 4; n++) begin
            @(negedge clk_rom);
            chk("dl_no_req", sdram_req, 0);
        end
        exp_q.push_back(22'h01000);
        exp_q.push_back(22'h03000);
        downloading = 1'b0;
        serve(1, 2, 32'h0000_1000);
        serve(1, 2, 32'h0000_3000);
        chk("dl_after_ok", ch_ok, 4'b0011);

        // Simultaneous ack and data_rdy, back-to-back grant.
        ch_req = 4'b1000;
        set_addr(3, 22'h04000);
        exp_q.push_back(22'h04000);
        wait_req();
        exp_q.push_back(22'h05000);
        set_addr(2, 22'h05000);
        ch_req = 4'b1100;
        @(negedge clk_rom);
        sdram_ack = 1'b1; data_rdy = 1'b1; data_read = 32'h4444_4444;
        @(negedge clk_rom);
        sdram_ack = 1'b0; data_rdy = 1'b0; data_read = '0;
        chk("sim_req_low", sdram_req, 0);
        chk("sim_ok3", ch_ok[3], 1);
        chk("sim_data3", data_of(3), 32'h4444_4444);
        @(negedge clk_rom);
        chk("sim_b2b_req", sdram_req, 1);
        serve(1, 2, 32'h5555_5555);
        chk("sim_ok2", ch_ok[2], 1);

        // Reset while waiting for ack.
        ch_req = 4'b1110;
        set_addr(1, 22'h06000);
        exp_q.push_back(22'h06000);
        wait_req();
        rst = 1'b1;
        @(negedge clk_rom);
        chk("rr_mid_req", sdram_req, 0);
        chk("rr_mid_ok", ch_ok, 0);
        @(negedge clk_rom);
        exp_q.push_back(22'h06000);
        exp_q.push_back(22'h05000);
        exp_q.push_back(22'h04000);
        rst = 1'b0;
        serve(1, 2, 32'h6666_6666);
        serve(1, 2, 32'h5555_0000);
        serve(1, 2, 32'h4444_0000);
        chk("rst_after_ok", ch_ok, 4'b1110);
        chk("rst_after_d1", data_of(1), 32'h6666_6666);

        repeat (4) @(negedge clk_rom);
        chk("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
